// File: rtl/cmd_pkg.sv
// Shared definitions for the UART command scheduler: opcodes, command payload,
// scheduler FSM states and the opcode legality check.
package cmd_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned BYTE_W = OP_W + DATA_W;
  localparam int unsigned GAP_W  = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_CLEAR = 4'h1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SHOW  = 4'h4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

  // Opcodes the executor understands; everything else is illegal.
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_CLEAR, OP_LOAD, OP_SHOW: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command FIFO (DEPTH x cmd_t). Occupancy, ready (not full) and empty
// are registered so downstream handshakes never see a same-cycle pass-through.
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  cmd_t             wdata,
  input  logic             pop,
  output cmd_t             rdata_c,
  output logic             ready,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic [LVL_W-1:0] level_d_c;

  assign push_ok_c = push & ready;
  assign pop_ok_c  = pop & ~empty;
  assign rdata_c   = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d_c = level;
    case ({push_ok_c, pop_ok_c})
      2'b10:   level_d_c = level + LVL_W'(1);
      2'b01:   level_d_c = level - LVL_W'(1);
      default: level_d_c = level;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d_c;
      ready <= (level_d_c != LVL_W'(DEPTH));
      empty <= (level_d_c == '0);
    end
  end

  // Storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge clock) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_cmd_sched.sv
// UART-to-executor command scheduler: buffers command bytes, issues them one
// at a time and inserts a NOP gap after each. Optional UART_CMD_SCHED_FILTER_EN
// drops illegal opcodes at the FIFO input and flags them in err_sticky.
module uart_cmd_sched
  import cmd_pkg::*;
#(
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned GAP_CYCLES = 2,
  localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_byte,
  output logic              rx_ready,
  output logic [OP_W-1:0]   exec_instr,
  output logic [DATA_W-1:0] exec_data,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [CNT_W-1:0]  cmd_count,
  output logic              err_sticky
);

  sched_state_e      state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              valid_d;
  logic [OP_W-1:0]   instr_d;
  logic [DATA_W-1:0] data_d;
  logic              pop_c;
  logic              count_inc_c;

  cmd_t              rx_cmd_c;
  cmd_t              head_c;
  logic              fifo_empty;
  logic              accept_c;
  logic              illegal_c;
  logic              push_c;
  logic              err_set_c;

  assign rx_cmd_c = cmd_t'(rx_byte);
  assign accept_c = rx_valid & rx_ready;

`ifdef UART_CMD_SCHED_FILTER_EN
  assign illegal_c = ~is_legal(rx_cmd_c.op);
`else
  assign illegal_c = 1'b0;
`endif

  // NOPs are consumed at the input and never occupy a FIFO slot.
  assign push_c    = accept_c & (rx_cmd_c.op != OP_NOP) & ~illegal_c;
  assign err_set_c = (rx_valid & ~rx_ready) | (accept_c & illegal_c);

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_c),
    .wdata   (rx_cmd_c),
    .pop     (pop_c),
    .rdata_c (head_c),
    .ready   (rx_ready),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Scheduler next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    valid_d     = exec_valid;
    instr_d     = exec_instr;
    data_d      = exec_data;
    pop_c       = 1'b0;
    count_inc_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          valid_d = 1'b1;
          instr_d = head_c.op;
          data_d  = head_c.data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (exec_ready) begin
          count_inc_c = 1'b1;
          valid_d     = 1'b0;
          instr_d     = OP_NOP;
          data_d      = '0;
          gap_d       = GAP_W'(GAP_CYCLES);
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
        instr_d = OP_NOP;
        data_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      exec_valid <= 1'b0;
      exec_instr <= OP_NOP;
      exec_data  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      exec_valid <= valid_d;
      exec_instr <= instr_d;
      exec_data  <= data_d;
    end
  end

  // Issue counter (free-running wrap) and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (count_inc_c) cmd_count <= cmd_count + CNT_W'(1);
      if (err_set_c)   err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Self-checking bench for uart_cmd_sched: directed stimulus with a scoreboard of
// expected issued commands, popped when exec_valid rises.
module tb_uart_cmd_sched;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       exec_ready = 1'b0;
  logic       rx_ready;
  logic [3:0] exec_instr;
  logic [3:0] exec_data;
  logic       exec_valid;
  logic [2:0] fifo_level;
  logic [7:0] cmd_count;
  logic       err_sticky;

  uart_cmd_sched #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .exec_instr (exec_instr),
    .exec_data  (exec_data),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .fifo_level (fifo_level),
    .cmd_count  (cmd_count),
    .err_sticky (err_sticky)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  int         exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: ordering, spacing, hold stability and idle-zero outputs.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_word = 8'h00;
  logic [7:0] exp_word;
  int         cyc = 0;
  int         last_rise = -1;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_valid = 1'b0;
        last_rise  = -1;
      end else begin
        if (exec_valid && !prev_valid) begin
          check("issue_expected", 32'(sb.size() != 0), 32'd1);
          if (last_rise >= 0) check("issue_spacing", 32'((cyc - last_rise) >= GAP + 2), 32'd1);
          last_rise = cyc;
          if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            check("issue_word", {24'h0, exec_instr, exec_data}, {24'h0, exp_word});
          end
        end else if (exec_valid && prev_valid) begin
          check("hold_stable", {24'h0, exec_instr, exec_data}, {24'h0, prev_word});
        end else begin
          check("idle_zero", {24'h0, exec_instr, exec_data}, 32'h0);
        end
        prev_valid = exec_valid;
        prev_word  = {exec_instr, exec_data};
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit expect_issue);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (expect_issue) begin
      sb.push_back(b);
      exp_count++;
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_ready(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    while (!rx_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1;
    rx_byte  = b;
    sb.push_back(b);
    exp_count++;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || fifo_level != 0 || exec_valid) && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("drain_done", 32'(n < limit), 32'd1);
    repeat (GAP + 2) @(negedge clock);
  endtask

  logic [7:0] burst[4];
  logic [7:0] stall[5];
  logic [3:0] legal_ops[3];

  initial begin
    burst     = '{8'h13, 8'h27, 8'h40, 8'h4F};
    stall     = '{8'h11, 8'h22, 8'h43, 8'h14, 8'h25};
    legal_ops = '{4'h1, 4'h2, 4'h4};

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_exec_valid", 32'(exec_valid), 32'd0);
    check("rst_instr_data", {24'h0, exec_instr, exec_data}, 32'h0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    reset = 1'b0;
    exec_ready = 1'b1;

    // Single byte latency
    @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = 8'h25;
    sb.push_back(8'h25);
    exp_count++;
    @(negedge clock);
    rx_valid = 1'b0;
    check("single_level1", 32'(fifo_level), 32'd1);
    check("single_not_yet", 32'(exec_valid), 32'd0);
    @(negedge clock);
    check("single_valid", 32'(exec_valid), 32'd1);
    check("single_instr", 32'(exec_instr), 32'd2);
    check("single_data", 32'(exec_data), 32'd5);
    check("single_level0", 32'(fifo_level), 32'd0);
    @(negedge clock);
    check("single_gap1", 32'(exec_valid), 32'd0);
    check("single_count", 32'(cmd_count), 32'd1);
    @(negedge clock);
    check("single_gap2", 32'(exec_valid), 32'd0);
    drain(50);

    // Back-to-back burst, ready tied high
    foreach (burst[i]) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = burst[i];
      sb.push_back(burst[i]);
      exp_count++;
    end
    @(negedge clock);
    rx_valid = 1'b0;
    drain(100);
    check("burst_count", 32'(cmd_count), 32'(exp_count));
    check("burst_err", 32'(err_sticky), 32'd0);

    // Pure NOP byte: consumed, nothing issued
    send(8'h07, 1'b0);
    check("nop_level", 32'(fifo_level), 32'd0);
    repeat (6) @(negedge clock);
    check("nop_count", 32'(cmd_count), 32'(exp_count));
    check("nop_no_issue", 32'(exec_valid), 32'd0);

    // Illegal opcode 3
`ifdef UART_CMD_SCHED_FILTER_EN
    send(8'h39, 1'b0);
    repeat (4) @(negedge clock);
    check("illegal_level", 32'(fifo_level), 32'd0);
    check("illegal_err", 32'(err_sticky), 32'd1);
    check("illegal_count", 32'(cmd_count), 32'(exp_count));
`else
    send(8'h39, 1'b1);
    drain(50);
    check("illegal_count", 32'(cmd_count), 32'(exp_count));
    check("illegal_err", 32'(err_sticky), 32'd0);
`endif

    // Executor stall: one in ISSUE, four fill the FIFO, fifth refused
    exec_ready = 1'b0;
    send(8'h2A, 1'b1);
    @(negedge clock);
    check("stall_issue", 32'(exec_valid), 32'd1);
    foreach (stall[i]) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = stall[i];
      if (i < DEPTH) begin
        sb.push_back(stall[i]);
        exp_count++;
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    check("stall_level", 32'(fifo_level), 32'd4);
    check("stall_ready", 32'(rx_ready), 32'd0);
    check("stall_err", 32'(err_sticky), 32'd1);
    repeat (2) @(negedge clock);
    check("stall_instr", {24'h0, exec_instr, exec_data}, 32'h2A);
    check("stall_valid", 32'(exec_valid), 32'd1);
    exec_ready = 1'b1;
    drain(100);
    check("stall_count", 32'(cmd_count), 32'(exp_count));

    // Reset during ISSUE with three commands queued
    exec_ready = 1'b0;
    send(8'h41, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = 8'h21 + 8'(i);
      sb.push_back(rx_byte);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    check("pre_rst_valid", 32'(exec_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    exp_count = 0;
    check("async_rst_valid", 32'(exec_valid), 32'd0);
    check("async_rst_instr_data", {24'h0, exec_instr, exec_data}, 32'h0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_count", 32'(cmd_count), 32'd0);
    check("async_rst_err", 32'(err_sticky), 32'd0);
    check("async_rst_ready", 32'(rx_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    exec_ready = 1'b1;
    repeat (12) @(negedge clock);
    check("post_rst_count", 32'(cmd_count), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    // 256 issues: counter wraps
    for (int i = 0; i < 255; i++) begin
      send_ready({legal_ops[i % 3], 4'(i)});
    end
    drain(400);
    check("count_255", 32'(cmd_count), 32'hFF);
    send_ready(8'h4C);
    drain(50);
    check("count_wrap", 32'(cmd_count), 32'h00);
    check("final_err", 32'(err_sticky), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_sched.md
# uart_cmd_sched

Command scheduler between the UART byte receiver and the instruction executor. Accepts command bytes (high nibble = opcode, low nibble = data), buffers them in a small FIFO, filters illegal opcodes, and issues them one at a time to the executor. After each issue it forces a NOP-gap so the executor returns to its idle/uart state before the next command. Sits directly upstream of the executor and drives its instruction and data inputs.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- GAP_CYCLES, 2: cycles of forced NOP after each accepted command, 1..15.
- clock  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  rx_byte is valid this cycle.
- rx_byte  in  8  [7:4] opcode, [3:0] data.
- rx_ready  out  1  FIFO can accept; a byte is written when rx_valid & rx_ready.
- exec_instr  out  4  opcode to executor; 0 (NOP) when not issuing.
- exec_data  out  4  data to executor; 0 when not issuing.
- exec_valid  out  1  command presented.
- exec_ready  in  1  executor idle and taking the command.
- fifo_level  out  log2(DEPTH)+1  current occupancy.
- cmd_count  out  8  commands handed to the executor, wraps 255->0.
- err_sticky  out  1  set on illegal opcode drop or on write attempt while full.

## Operation
- Opcodes: 0 NOP, 1 CLEAR, 2 LOAD, 4 SHOW; all others illegal.
- NOP bytes are accepted and discarded; they are not written to the FIFO.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: exec_valid=0, instr/data=0. FIFO non-empty -> load head into output registers, pop, go ISSUE.
  - ISSUE: exec_valid=1, outputs held stable. exec_ready=1 -> cmd_count+1, go GAP with counter=GAP_CYCLES.
  - GAP: exec_valid=0, instr/data=0. Decrement; at 1 -> IDLE.
- A write attempt while full (rx_valid & !rx_ready) sets err_sticky; the byte is lost.
- err_sticky is cleared only by reset.
- FIFO: circular, pointers wrap at DEPTH; push and pop in the same cycle leave the level unchanged.
- rx_ready = !full. It is computed from the registered level, with no same-cycle pass-through.

## Timing
- Reset values: rx_ready=1, exec_valid=0, exec_instr=0, exec_data=0, fifo_level=0, cmd_count=0, err_sticky=0, state IDLE.
- Reset mid-issue discards the FIFO contents and the in-flight command; outputs return to reset values asynchronously.
- Latency, byte accepted at edge N, FIFO empty, FSM idle:
  - fifo_level=1 after edge N.
  - exec_valid=1 after edge N+1.
- Minimum spacing between exec_valid rising edges is GAP_CYCLES+2 clocks.
- exec_instr/exec_data change only on the edge that enters ISSUE or leaves it.
- Push while popping at full: the pop frees the slot next cycle; that cycle's push is still refused.

## Configuration
- UART_CMD_SCHED_FILTER_EN defined: illegal opcodes are dropped at the FIFO input and set err_sticky.
- Not defined: illegal opcodes are queued and issued like legal ones; err_sticky only reflects overflow.

## Structure
- Shared package cmd_pkg holds:
  - opcode constants OP_NOP=0, OP_CLEAR=1, OP_LOAD=2, OP_SHOW=4;
  - the FSM state enum;
  - function is_legal(op).
- One sub-module, cmd_fifo (DEPTH x 8, push/pop/full/empty/level), instantiated once; the FSM and counters live in the top.

## Test plan
- Single byte 0x25, exec_ready=1:
  - exec_valid high 2 cycles after accept with instr=2, data=5;
  - then 2 NOP cycles;
  - cmd_count=1.
- Burst 0x13, 0x27, 0x40, 0x4F with exec_ready tied 1:
  - issued in order;
  - each separated by GAP_CYCLES NOP cycles;
  - cmd_count=4, err_sticky=0.
- exec_ready=0 for 10 cycles while 5 bytes arrive (DEPTH=4):
  - one byte refused, err_sticky=1, fifo_level=4;
  - exec_instr/data stable throughout the stall.
- Byte 0x39 with filter enabled: not issued, err_sticky=1, fifo_level=0. Filter disabled: issued as instr=3, data=9.
- Byte 0x07: no issue, cmd_count unchanged.
- Reset asserted during ISSUE with 3 queued: all outputs at reset values immediately, no further issue after release.
- 256 commands issued: cmd_count wraps to 0.
